cache_req_arbiter: RTL and testbench

//  Clocked round-robin arbiter that shares one cache replacement-update port among NUM_REQ requesters.

---
 rtl/cache_req_arbiter.sv | 145 ++++++++++++++
 tb/tb_cache_req_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: shares one replacement-update port among NUM_REQ
// requesters. A request is granted in IDLE, its payload is registered and
// held on o_driveNext/o_data/o_src until the downstream accepts it. Each
// accepted transfer is counted as outstanding until an i_done returns.
// When the count reaches MAX_OUT, grants stall.
// Build option: define CACHE_ARB_FIXED_PRIO_EN for fixed priority, where the
// lowest index wins. The default build uses round-robin.
module cache_req_arbiter #(
    parameter  int NUM_REQ = 2,
    parameter  int DATA_W  = 1,
    parameter  int MAX_OUT = 4,
    localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          i_drive,
    input  logic [NUM_REQ*DATA_W-1:0]   i_data,
    output logic [NUM_REQ-1:0]          o_free,
    output logic                        o_driveNext,
    output logic [DATA_W-1:0]           o_data,
    output logic [SRC_W-1:0]            o_src,
    input  logic                        i_freeNext,
    input  logic                        i_done,
    output logic [CNT_W-1:0]            o_outstanding,
    output logic                        o_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic [SRC_W-1:0]    r_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_err;
    logic [NUM_REQ-1:0]  r_free;
    logic                r_drive_next;
    logic [DATA_W-1:0]   r_data;
    logic [SRC_W-1:0]    r_src;

    logic [DATA_W-1:0]   w_req_data [NUM_REQ];
    logic [NUM_REQ-1:0]  w_eligible;
    logic                w_any;
    logic [SRC_W-1:0]    w_winner;
    logic [SRC_W-1:0]    w_idx;
    logic                w_inc;
    logic                w_dec;

    // Requester index (base + off) modulo NUM_REQ. Both operands are below
    // NUM_REQ, so one conditional subtraction is enough.
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base,
                                                  input logic [SRC_W:0]   off);
        logic [SRC_W:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= (SRC_W+1)'(NUM_REQ)) sum = sum - (SRC_W+1)'(NUM_REQ);
        return sum[SRC_W-1:0];
    endfunction

    // Split the flat payload bus into one entry per requester.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) w_req_data[k] = i_data[k*DATA_W +: DATA_W];
    end

    // Pick the first eligible requester, searching upward from the pointer with wrap.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        w_eligible = (r_count < CNT_W'(MAX_OUT)) ? i_drive : '0;
        w_any      = 1'b0;
        w_winner   = '0;
        w_idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = wrap_add(r_ptr, (SRC_W+1)'(i));
            if (!w_any && w_eligible[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // The transfer completes when downstream accepts it. A completion pulse frees a slot.
    assign w_inc = (r_state == ST_BUSY) && i_freeNext;
    assign w_dec = i_done;

    // Grant FSM with registered handshake outputs and the pointer update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_free       <= '0;
            r_drive_next <= 1'b0;
            r_data       <= '0;
            r_src        <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments, so every branch reads pre-edge values.
            r_free <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state      <= ST_BUSY;
                        r_data       <= w_req_data[w_winner];
                        r_src        <= w_winner;
                        r_drive_next <= 1'b1;
                        r_free       <= NUM_REQ'(1) << w_winner;
                    end
                end
                ST_BUSY: begin
                    if (i_freeNext) begin
                        r_state      <= ST_IDLE;
                        r_drive_next <= 1'b0;
`ifdef CACHE_ARB_FIXED_PRIO_EN
                        r_ptr        <= '0;
`else
                        r_ptr        <= wrap_add(r_src, (SRC_W+1)'(1));
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outstanding counter. A completion and an i_done in the same cycle
    // cancel out. An i_done at zero sets the sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (w_inc && !w_dec) begin
            r_count <= r_count + CNT_W'(1);
        end else if (!w_inc && w_dec) begin
            if (r_count == '0) r_err   <= 1'b1;
            else               r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_free        = r_free;
    assign o_driveNext   = r_drive_next;
    assign o_data        = r_data;
    assign o_src         = r_src;
    assign o_outstanding = r_count;
    assign o_err         = r_err;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Self-checking bench for cache_req_arbiter. A transaction-level model
// covers the search order, the outstanding count and the sticky error.
// Each scenario task compares the DUT against this model and against
// constant expectations.
module tb_cache_req_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 8;
    localparam int MAX_OUT = 4;
    localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);
    localparam int VEC_W   = NUM_REQ + 1 + DATA_W + SRC_W + CNT_W + 1;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        i_drive;
    logic [NUM_REQ*DATA_W-1:0] i_data;
    logic [NUM_REQ-1:0]        o_free;
    logic                      o_driveNext;
    logic [DATA_W-1:0]         o_data;
    logic [SRC_W-1:0]          o_src;
    logic                      i_freeNext;
    logic                      i_done;
    logic [CNT_W-1:0]          o_outstanding;
    logic                      o_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit                 m_busy;
    int                 m_ptr;
    int                 m_count;
    bit                 m_err;
    logic [NUM_REQ-1:0] m_free;
    bit                 m_drive;
    logic [DATA_W-1:0]  m_data;
    int                 m_src;

    cache_req_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_drive       (i_drive),
        .i_data        (i_data),
        .o_free        (o_free),
        .o_driveNext   (o_driveNext),
        .o_data        (o_data),
        .o_src         (o_src),
        .i_freeNext    (i_freeNext),
        .i_done        (i_done),
        .o_outstanding (o_outstanding),
        .o_err         (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VEC_W-1:0] obs_vec();
        return {o_free, o_driveNext, o_data, o_src, o_outstanding, o_err};
    endfunction

    function automatic logic [VEC_W-1:0] exp_vec();
        return {m_free, m_drive, m_data, SRC_W'(m_src), CNT_W'(m_count), m_err};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_ptr = 0; m_count = 0; m_err = 0;
        m_free = '0; m_drive = 0; m_data = '0; m_src = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int old_count;
        int win;
        int inc;
        old_count = m_count;
        inc       = 0;
        m_free    = '0;
        if (!m_busy) begin
            if (old_count < MAX_OUT && i_drive != '0) begin
                win = -1;
                for (int j = 0; j < NUM_REQ; j++) begin
                    int c;
                    c = (m_ptr + j) % NUM_REQ;
                    if (win < 0 && i_drive[c]) win = c;
                end
                m_busy  = 1;
                m_drive = 1;
                m_src   = win;
                m_data  = i_data[win*DATA_W +: DATA_W];
                m_free  = NUM_REQ'(1) << win;
            end
        end else if (i_freeNext) begin
            m_busy  = 0;
            m_drive = 0;
            inc     = 1;
`ifndef CACHE_ARB_FIXED_PRIO_EN
            m_ptr   = (m_src + 1) % NUM_REQ;
`endif
        end
        m_count = old_count + inc - (i_done ? 1 : 0);
        if (m_count < 0) begin
            m_count = 0;
            m_err   = 1;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // A requester drops its request right after its free pulse and re-raises it later.
    task automatic drive_reqs(input logic [NUM_REQ-1:0] want);
        i_drive = want & ~m_free;
        i_data  = (NUM_REQ*DATA_W)'($urandom);
    endtask

    task automatic apply_reset();
        rst = 1'b0; i_drive = '0; i_data = '0; i_freeNext = 1'b0; i_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; i_drive = '0; i_data = '0; i_freeNext = 1'b0; i_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (obs_vec() !== '0) begin
            n_fail++; $display("FAIL reset_state: got %h expected 0", obs_vec());
        end
        rst = 1'b1;
        i_freeNext = 1'b1;
        drive_reqs('1);
        cycle();
        n_tests++;
        if (o_src !== SRC_W'(0) || o_free !== NUM_REQ'(1)) begin
            n_fail++; $display("FAIL first_grant: got src %0d free %b expected src 0 free 001", o_src, o_free);
        end
        drive_reqs('1); cycle();
        i_freeNext = 1'b0;
        drive_reqs('1); cycle();
        drive_reqs('1); cycle();
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL pre_reset_busy: got %h expected %h", obs_vec(), exp_vec());
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({o_driveNext, o_free, o_outstanding, o_err} !== '0) begin
            n_fail++; $display("FAIL async_reset: got drv %b free %b cnt %0d err %b expected all 0",
                               o_driveNext, o_free, o_outstanding, o_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        i_freeNext = 1'b1;
        i_drive = '1;
        cycle();
        n_tests++;
        if (o_src !== SRC_W'(0) || o_free !== NUM_REQ'(1) || o_driveNext !== 1'b1) begin
            n_fail++; $display("FAIL grant_after_reset: got src %0d free %b drv %b expected src 0 free 001 drv 1",
                               o_src, o_free, o_driveNext);
        end
    endtask

    task automatic test_rr_fairness();
        int src_q[$];
        int exp_src [4];
`ifdef CACHE_ARB_FIXED_PRIO_EN
        exp_src = '{0, 0, 0, 0};
`else
        exp_src = '{0, 1, 0, 1};
`endif
        apply_reset();
        i_freeNext = 1'b1;
        for (int c = 0; c < 8; c++) begin
            drive_reqs(NUM_REQ'(3));
            i_done = m_busy;
            cycle();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rr_cycle%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
            if (o_free != '0) src_q.push_back(int'(o_src));
        end
        i_done = 1'b0;
        n_tests++;
        if (src_q.size() != 4) begin
            n_fail++; $display("FAIL rr_grant_count: got %0d expected 4", src_q.size());
        end else begin
            for (int g = 0; g < 4; g++) begin
                n_tests++;
                if (src_q[g] != exp_src[g]) begin
                    n_fail++; $display("FAIL rr_seq%0d: got src %0d expected %0d", g, src_q[g], exp_src[g]);
                end
            end
        end
        n_tests++;
        if (o_outstanding !== CNT_W'(0) || o_err !== 1'b0) begin
            n_fail++; $display("FAIL rr_count: got %0d err %b expected 0 err 0", o_outstanding, o_err);
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] held;
        apply_reset();
        i_freeNext = 1'b0;
        drive_reqs(NUM_REQ'(4));
        held = i_data[2*DATA_W +: DATA_W];
        cycle();
        for (int c = 0; c < 5; c++) begin
            drive_reqs('1);
            cycle();
            n_tests++;
            if (o_driveNext !== 1'b1 || o_data !== held || o_src !== SRC_W'(2) || o_free !== '0) begin
                n_fail++; $display("FAIL backpressure%0d: got drv %b data %h src %0d free %b expected 1 %h 2 000",
                                   c, o_driveNext, o_data, o_src, o_free, held);
            end
        end
        i_freeNext = 1'b1;
        drive_reqs('1); cycle();
        drive_reqs('1); cycle();
        n_tests++;
        if (obs_vec() !== exp_vec() || o_src !== SRC_W'(0)) begin
            n_fail++; $display("FAIL bp_release: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_outstanding_limit();
        apply_reset();
        i_freeNext = 1'b1;
        for (int c = 0; c < 8; c++) begin
            drive_reqs('1);
            cycle();
        end
        for (int c = 0; c < 4; c++) begin
            drive_reqs('1);
            cycle();
            n_tests++;
            if (o_free !== '0 || o_outstanding !== CNT_W'(MAX_OUT) || o_driveNext !== 1'b0) begin
                n_fail++; $display("FAIL limit_stall%0d: got free %b cnt %0d drv %b expected 000 %0d 0",
                                   c, o_free, o_outstanding, o_driveNext, MAX_OUT);
            end
        end
        drive_reqs('1);
        i_done = 1'b1;
        cycle();
        i_done = 1'b0;
        n_tests++;
        if (o_free !== '0 || o_outstanding !== CNT_W'(MAX_OUT - 1)) begin
            n_fail++; $display("FAIL limit_release: got free %b cnt %0d expected 000 %0d",
                               o_free, o_outstanding, MAX_OUT - 1);
        end
        drive_reqs('1);
        cycle();
        n_tests++;
        if (o_free === '0 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL limit_regrant: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        i_freeNext = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive_reqs(NUM_REQ'(1));
            cycle();
        end
        drive_reqs('0);
        i_done = 1'b1;
        cycle();
        n_tests++;
        if (o_outstanding !== CNT_W'(2) || o_driveNext !== 1'b0 || o_err !== 1'b0) begin
            n_fail++; $display("FAIL inc_dec_same: got cnt %0d drv %b err %b expected 2 0 0",
                               o_outstanding, o_driveNext, o_err);
        end
        cycle();
        cycle();
        n_tests++;
        if (o_outstanding !== CNT_W'(0) || o_err !== 1'b0) begin
            n_fail++; $display("FAIL drain: got cnt %0d err %b expected 0 0", o_outstanding, o_err);
        end
        cycle();
        i_done = 1'b0;
        n_tests++;
        if (o_outstanding !== CNT_W'(0) || o_err !== 1'b1) begin
            n_fail++; $display("FAIL underflow: got cnt %0d err %b expected 0 1", o_outstanding, o_err);
        end
        repeat (3) cycle();
        n_tests++;
        if (o_err !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL err_sticky: got err %b vec %h expected err 1 vec %h", o_err, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (m_free[k])       i_drive[k] = 1'b0;
                else if (!i_drive[k]) i_drive[k] = ($urandom_range(0, 2) == 0);
            end
            i_data     = (NUM_REQ*DATA_W)'($urandom);
            i_freeNext = ($urandom_range(0, 3) != 0);
            i_done     = (m_count > 0) && ($urandom_range(0, 2) == 0);
            cycle();
            n_tests++;
            if (obs_vec() !== exp_vec() || $countones(o_free) > 1) begin
                n_fail++; $display("FAIL random%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        i_drive = '0; i_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rr_fairness();
        test_backpressure();
        test_outstanding_limit();
        test_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
